jsv_float_to_fixed: RTL and testbench
=====================================

Name: jsv_float_to_fixed

Overview:
- Consumes the 32-bit IEEE-754 single-precision value driven by the Avalon PIO shortreal output register.
- Converts it to the signed fixed-point format used by the Julia-set iteration engine: Q(OUT_W-FRAC_BITS).FRAC_BITS, two's complement.
- Detects value changes itself, so software writes to the PIO re-launch a conversion automatically.
- Delivers the result through a valid/ready handshake, with overflow and NaN flags.

Parameters:
- OUT_W, 32, fixed-point output width.
- FRAC_BITS, 28, fractional bits. Default format is Q4.28, range [-8.0, +8.0).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- float_in  in  32  IEEE-754 single, from the PIO output register.
- fixed_out  out  OUT_W  converted value; held until the next result.
- out_valid  out  1  result available; held until accepted.
- out_ready  in  1  consumer accepts the result.
- ovf  out  1  result saturated (magnitude too large, or infinity); valid with out_valid.
- nan  out  1  input was NaN, result forced to 0; valid with out_valid.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (sync, high), applied any cycle including mid-conversion:
  - state=IDLE, fixed_out=0, out_valid=0, ovf=0, nan=0, busy=0.
  - last_q=0; force_q=1 so the current float_in is converted after reset releases.
- FSM states: IDLE -> UNPACK -> SHIFT -> ROUND -> DONE -> IDLE.
- IDLE:
  - Launch when (float_in != last_q) or force_q.
  - On launch: in_q<=float_in, last_q<=float_in, force_q<=0, go to UNPACK.
- UNPACK:
  - s = in_q[31], e = in_q[30:23], m = {1, in_q[22:0]}.
  - Classify: zero/denormal (e==0), inf (e==255, frac==0), NaN (e==255, frac!=0), normal.
  - sh = e - 127 + FRAC_BITS - 23, computed as a signed 10-bit value.
- SHIFT, normal inputs:
  - sh >= 0: mag = m << sh, computed in at least OUT_W+1 bits; overflow if any bit at or above OUT_W-1 is set after the shift.
  - sh < 0: mag = m >> -sh, keeping the round bit (last bit shifted out).
  - -sh > 25: mag=0, round=0.
- ROUND:
  - Add the round bit to the magnitude (round half away from zero).
  - Apply the sign by two's complement.
  - Saturate positive results > 2^(OUT_W-1)-1 to 0x7FFFFFFF, ovf=1.
  - Saturate negative magnitudes > 2^(OUT_W-1) to 0x80000000, ovf=1.
  - A negative magnitude exactly 2^(OUT_W-1) is legal: result 0x80000000, ovf=0.
  - Infinity: saturate by sign, ovf=1.
  - NaN: result 0, nan=1.
  - Zero/denormal: result 0, both flags 0.
- DONE:
  - On entry, register fixed_out, ovf, nan; set out_valid=1.
  - Latency: launch in cycle N gives out_valid high from cycle N+4.
  - Hold all outputs while out_ready=0.
  - On out_valid && out_ready: out_valid<=0, go to IDLE. fixed_out, ovf and nan keep their last values.
- float_in changing while busy:
  - Not sampled mid-conversion.
  - Compared against last_q in the next IDLE cycle, so the last write is never lost. Intermediate writes may be skipped.
- Back-to-back: after acceptance, at least one IDLE cycle precedes the next launch.
- busy = (state != IDLE).

Decomposition:
- Package jsv_fixed_pkg:
  - Constants: OUT_W, FRAC_BITS, FLOAT_BIAS=127, MANT_W=24, FIX_MAX, FIX_MIN.
  - State enum f2x_state_t {IDLE, UNPACK, SHIFT, ROUND, DONE}.
  - Class enum {F_ZERO, F_NORM, F_INF, F_NAN}.
- One sub-module, jsv_f2x_shifter: combinational bidirectional barrel shift of the 24-bit mantissa by signed sh, producing the magnitude, the round bit and the overflow flag. Instantiated in the SHIFT stage.

Test Plan:
- Reset release with float_in=0x3F800000 (1.0) -> out_valid rises 4 cycles after first IDLE cycle; fixed_out=0x10000000, ovf=0, nan=0.
- Sign and fraction:
  - 0xC0000000 (-2.0) -> 0xE0000000.
  - 0x3F000000 (0.5) -> 0x08000000.
  - 0xBE800000 (-0.25) -> 0xFC000000.
- Saturation:
  - 0x41200000 (10.0) -> 0x7FFFFFFF, ovf=1.
  - 0xC1000000 (-8.0) -> 0x80000000, ovf=0.
  - 0xFF800000 (-inf) -> 0x80000000, ovf=1.
- Rounding and special cases:
  - 0x31000000 (2^-29) -> 0x00000001.
  - 0x30800000 (2^-30) -> 0x00000000.
  - 0x7FC00000 (NaN) -> 0x00000000, nan=1.
  - 0x00000001 (denormal) -> 0.
- Handshake: hold out_ready=0 for 10 cycles and change float_in to 0x40000000 during the hold -> outputs stable; after acceptance, second result 0x20000000 appears without a further input change.
- Reset asserted in SHIFT state -> next cycle out_valid=0, fixed_out=0; the current float_in is reconverted after release.

Source files
------------

// File: rtl/jsv_fixed_pkg.sv
// Shared constants and enums for the float-to-fixed converter.
// Default fixed-point format is Q4.28.
package jsv_fixed_pkg;

  localparam int OUT_W      = 32;
  localparam int FRAC_BITS  = 28;
  localparam int FLOAT_BIAS = 127;
  localparam int MANT_W     = 24;

  localparam logic [OUT_W-1:0] FIX_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] FIX_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    SHIFT  = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } f2x_state_t;

  typedef enum logic [1:0] {
    F_ZERO = 2'd0,
    F_NORM = 2'd1,
    F_INF  = 2'd2,
    F_NAN  = 2'd3
  } f2x_class_t;

endpackage

// File: rtl/jsv_f2x_shifter.sv
// Bidirectional barrel shift of the 24-bit mantissa by a signed amount.
// Left shifts report overflow; right shifts keep the last bit shifted out.
module jsv_f2x_shifter #(
  parameter int OUT_W = 32
) (
  input  logic [23:0]       mant_i,
  input  logic signed [9:0] sh_i,
  output logic [OUT_W:0]    mag_o,
  output logic              rnd_o,
  output logic              ovf_o
);
  import jsv_fixed_pkg::*;

  localparam int MAG_W = OUT_W + 1;
  // Largest left shift that still fits the mantissa MSB inside OUT_W bits.
  localparam logic signed [9:0] MAX_LSH = 10'(OUT_W - MANT_W);
  localparam logic [9:0]        MAX_RSH = 10'(MANT_W + 1);

  logic [9:0]       rsh_s;
  logic [MANT_W:0]  rext_s;
  logic [MAG_W-1:0] mag_s;
  logic             rnd_s;

  // Select shift direction; oversized left shifts clamp to an all-ones magnitude.
  always_comb begin
    mag_s  = '0;
    rnd_s  = 1'b0;
    rsh_s  = 10'd0;
    rext_s = '0;
    if (!sh_i[9]) begin
      if (sh_i > MAX_LSH) begin
        mag_s = '1;
      end else begin
        mag_s = MAG_W'(mant_i) << $unsigned(sh_i);
      end
    end else begin
      rsh_s = 10'(-sh_i);
      if (rsh_s > MAX_RSH) begin
        mag_s = '0;
        rnd_s = 1'b0;
      end else begin
        rext_s = {mant_i, 1'b0} >> rsh_s;
        mag_s  = MAG_W'(rext_s[MANT_W:1]);
        rnd_s  = rext_s[0];
      end
    end
  end

  assign mag_o = mag_s;
  assign rnd_o = rnd_s;
  assign ovf_o = |mag_s[MAG_W-1:OUT_W-1];

endmodule

// File: rtl/jsv_float_to_fixed.sv
// Converts an IEEE-754 single from a PIO register into signed fixed point,
// relaunching whenever the input changes, with a valid/ready result port.
module jsv_float_to_fixed #(
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      float_in,
  output logic [OUT_W-1:0] fixed_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             nan,
  output logic             busy
);
  import jsv_fixed_pkg::*;

  localparam logic signed [9:0] SH_OFS  = 10'(FLOAT_BIAS - FRAC_BITS + MANT_W - 1);
  localparam logic [OUT_W-1:0]  SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]  SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W+1:0]  POS_LIM = {3'b000, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W+1:0]  NEG_LIM = {3'b001, {(OUT_W-1){1'b0}}};

  f2x_state_t        state_q;
  f2x_class_t        cls_q, cls_d;
  logic [31:0]       in_q, last_q;
  logic              force_q;
  logic              sign_q;
  logic signed [9:0] sh_q, sh_d;
  logic [23:0]       mant_q;
  logic [OUT_W:0]    mag_q, mag_d;
  logic              rnd_q, rnd_d;
  logic              shf_ovf_q, shf_ovf_d;
  logic [OUT_W-1:0]  fixed_q, fixed_d;
  logic              ovf_q, ovf_d, nan_q, nan_d;
  logic              valid_q, busy_q;
  logic [OUT_W+1:0]  total_s;

  // Unpack: classify the captured float and derive the signed shift amount.
  always_comb begin
    cls_d = F_NORM;
    sh_d  = $signed({2'b00, in_q[30:23]}) - SH_OFS;
    if (in_q[30:23] == 8'd0) begin
      cls_d = F_ZERO;
    end else if (in_q[30:23] == 8'hFF) begin
      cls_d = (in_q[22:0] == 23'd0) ? F_INF : F_NAN;
    end else begin
      cls_d = F_NORM;
    end
  end

  jsv_f2x_shifter #(.OUT_W(OUT_W)) u_shifter (
    .mant_i (mant_q),
    .sh_i   (sh_q),
    .mag_o  (mag_d),
    .rnd_o  (rnd_d),
    .ovf_o  (shf_ovf_d)
  );

  assign total_s = {1'b0, mag_q} + {{(OUT_W+1){1'b0}}, rnd_q};

  // Round half away from zero, apply sign, saturate; -2^(OUT_W-1) is exact.
  always_comb begin
    fixed_d = '0;
    ovf_d   = 1'b0;
    nan_d   = 1'b0;
    case (cls_q)
      F_ZERO: begin
        fixed_d = '0;
      end
      F_NAN: begin
        nan_d = 1'b1;
      end
      F_INF: begin
        fixed_d = sign_q ? SAT_MIN : SAT_MAX;
        ovf_d   = 1'b1;
      end
      F_NORM: begin
        if (!sign_q) begin
          if (shf_ovf_q || (total_s > POS_LIM)) begin
            fixed_d = SAT_MAX;
            ovf_d   = 1'b1;
          end else begin
            fixed_d = total_s[OUT_W-1:0];
          end
        end else begin
          if (total_s > NEG_LIM) begin
            fixed_d = SAT_MIN;
            ovf_d   = 1'b1;
          end else begin
            fixed_d = ~total_s[OUT_W-1:0] + {{(OUT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        fixed_d = '0;
      end
    endcase
  end

  // Conversion FSM with pipeline registers and registered result port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      in_q      <= 32'd0;
      last_q    <= 32'd0;
      force_q   <= 1'b1;
      cls_q     <= F_ZERO;
      sign_q    <= 1'b0;
      sh_q      <= 10'sd0;
      mant_q    <= 24'd0;
      mag_q     <= '0;
      rnd_q     <= 1'b0;
      shf_ovf_q <= 1'b0;
      fixed_q   <= '0;
      ovf_q     <= 1'b0;
      nan_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((float_in != last_q) || force_q) begin
            in_q    <= float_in;
            last_q  <= float_in;
            force_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          cls_q   <= cls_d;
          sign_q  <= in_q[31];
          sh_q    <= sh_d;
          mant_q  <= {1'b1, in_q[22:0]};
          state_q <= SHIFT;
        end
        SHIFT: begin
          mag_q     <= mag_d;
          rnd_q     <= rnd_d;
          shf_ovf_q <= shf_ovf_d;
          state_q   <= ROUND;
        end
        ROUND: begin
          fixed_q <= fixed_d;
          ovf_q   <= ovf_d;
          nan_q   <= nan_d;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fixed_out = fixed_q;
  assign out_valid = valid_q;
  assign ovf       = ovf_q;
  assign nan       = nan_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_jsv_float_to_fixed.sv
// Directed bench for jsv_float_to_fixed: reset, conversion vectors,
// saturation, rounding/special cases, handshake hold and mid-run reset.
module tb_jsv_float_to_fixed;

  typedef struct packed {
    logic [31:0] f;
    logic [31:0] x;
    logic        o;
    logic        n;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] float_in;
  logic [31:0] fixed_out;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic        nan;
  logic        busy;

  int tests = 0;
  int fails = 0;

  jsv_float_to_fixed dut (
    .clk       (clk),
    .reset     (reset),
    .float_in  (float_in),
    .fixed_out (fixed_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .nan       (nan),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drive a new input (DUT idle) and wait a bounded time for out_valid.
  task automatic launch_and_wait(input logic [31:0] f, output bit ok);
    float_in  = f;
    out_ready = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Accept the pending result and confirm out_valid drops.
  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL accept_drop: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic run_vectors(input string name, input vec_t v[]);
    bit ok;
    foreach (v[i]) begin
      launch_and_wait(v[i].f, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL %s_timeout[%0d]: in=%h no out_valid", name, i, v[i].f);
      end
      tests++;
      if ({fixed_out, ovf, nan} !== {v[i].x, v[i].o, v[i].n}) begin
        fails++;
        $display("FAIL %s[%0d]: in=%h got fix=%h ovf=%b nan=%b want fix=%h ovf=%b nan=%b",
                 name, i, v[i].f, fixed_out, ovf, nan, v[i].x, v[i].o, v[i].n);
      end
      accept();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    float_in = 32'h3F80_0000;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({out_valid, busy, ovf, nan, fixed_out} !== 36'h0) begin
      fails++;
      $display("FAIL reset_state: valid=%b busy=%b ovf=%b nan=%b fix=%h want all 0",
               out_valid, busy, ovf, nan, fixed_out);
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== (i == 4) || busy !== 1'b1) begin
        fails++;
        $display("FAIL latency[%0d]: out_valid=%b busy=%b want valid=%b busy=1",
                 i, out_valid, busy, (i == 4));
      end
    end
    tests++;
    if ({fixed_out, ovf, nan} !== {32'h1000_0000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_release_conv: fix=%h ovf=%b nan=%b want 10000000 0 0",
               fixed_out, ovf, nan);
    end
    accept();
  endtask

  task automatic test_sign_fraction();
    vec_t v[] = '{
      '{32'hC000_0000, 32'hE000_0000, 1'b0, 1'b0},
      '{32'h3F00_0000, 32'h0800_0000, 1'b0, 1'b0},
      '{32'hBE80_0000, 32'hFC00_0000, 1'b0, 1'b0},
      '{32'h40FF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0}
    };
    run_vectors("sign_frac", v);
  endtask

  task automatic test_saturation();
    vec_t v[] = '{
      '{32'h4120_0000, 32'h7FFF_FFFF, 1'b1, 1'b0},
      '{32'hC100_0000, 32'h8000_0000, 1'b0, 1'b0},
      '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0},
      '{32'h4100_0000, 32'h7FFF_FFFF, 1'b1, 1'b0},
      '{32'hC100_0001, 32'h8000_0000, 1'b1, 1'b0},
      '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0},
      '{32'h7F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0}
    };
    run_vectors("saturate", v);
  endtask

  task automatic test_round_special();
    vec_t v[] = '{
      '{32'h3100_0000, 32'h0000_0001, 1'b0, 1'b0},
      '{32'h3080_0000, 32'h0000_0000, 1'b0, 1'b0},
      '{32'hB100_0000, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{32'h3240_0000, 32'h0000_0003, 1'b0, 1'b0},
      '{32'h3220_0000, 32'h0000_0003, 1'b0, 1'b0},
      '{32'hB220_0000, 32'hFFFF_FFFD, 1'b0, 1'b0},
      '{32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1},
      '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0},
      '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0}
    };
    run_vectors("round_special", v);
  endtask

  task automatic test_handshake();
    bit ok;
    launch_and_wait(32'h3F80_0000, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL hs_first_timeout: no out_valid");
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) float_in = 32'h4000_0000;
      @(negedge clk);
      tests++;
      if ({out_valid, busy, fixed_out, ovf, nan} !== {1'b1, 1'b1, 32'h1000_0000, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL hs_hold[%0d]: valid=%b busy=%b fix=%h ovf=%b nan=%b want 1 1 10000000 0 0",
                 i, out_valid, busy, fixed_out, ovf, nan);
      end
    end
    accept();
    tests++;
    if (busy !== 1'b0 || fixed_out !== 32'h1000_0000) begin
      fails++;
      $display("FAIL hs_idle_gap: busy=%b fix=%h want busy=0 fix=10000000", busy, fixed_out);
    end
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok || fixed_out !== 32'h2000_0000) begin
      fails++;
      $display("FAIL hs_second: valid_seen=%b fix=%h want 1 20000000", ok, fixed_out);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    bit ok;
    float_in = 32'hC000_0000;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_busy: busy=%b valid=%b want 1 0", busy, out_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, busy, fixed_out} !== {1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL mid_reset: valid=%b busy=%b fix=%h want 0 0 00000000",
               out_valid, busy, fixed_out);
    end
    reset = 1'b0;
    launch_and_wait(32'hC000_0000, ok);
    tests++;
    if (!ok || {fixed_out, ovf, nan} !== {32'hE000_0000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL mid_reconvert: valid_seen=%b fix=%h ovf=%b nan=%b want 1 E0000000 0 0",
               ok, fixed_out, ovf, nan);
    end
    accept();
  endtask

  initial begin
    reset     = 1'b1;
    float_in  = 32'h0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sign_fraction();
    test_saturation();
    test_round_special();
    test_handshake();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
